// File: rtl/pipeline_pow2n_pkg.sv
// Shared helpers for the repeated-squaring pipeline: width derivations and
// the bit offsets used to pack all stage levels into one flat vector.
package pipeline_pow2n_pkg;

  // Ceiling log2, used to size the occupancy counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Result width after `stages` squarings of an `in_w`-bit operand.
  function automatic int out_width(input int in_w, input int stages);
    return in_w << stages;
  endfunction

  // Offset of level k in the flat data vector; level k is (in_w << k) bits wide.
  function automatic int lvl_off(input int in_w, input int k);
    return in_w * ((1 << k) - 1);
  endfunction

endpackage

// File: rtl/pipeline_pow2n_sq_stage.sv
// One squaring register stage: valid bit, 2W-bit square, and pass-through tag.
module pipeline_sq_stage #(
  parameter int W     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             in_v,
  input  logic [W-1:0]     in_d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_v,
  output logic [2*W-1:0]   out_d,
  output logic [TAG_W-1:0] out_tag
);

  logic [2*W-1:0] ext;
  logic [2*W-1:0] sq;

  // Zero-extend before multiplying so the full 2W-bit product is kept.
  assign ext = {{W{1'b0}}, in_d};
  assign sq  = ext * ext;

  // Advance when enabled; data and tag only load from a valid source.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_v   <= 1'b0;
      out_d   <= '0;
      out_tag <= '0;
    end else if (en) begin
      out_v <= in_v;
      if (in_v) begin
        out_d   <= sq;
        out_tag <= in_tag;
      end
    end
  end

endmodule

// File: rtl/pipeline_pow2n.sv
// Pipelined x^(2^STAGES) by repeated squaring with valid/ready backpressure,
// bubble collapsing, a pass-through tag and an in-flight item counter.
module pipeline_pow2n
  import pipeline_pow2n_pkg::*;
#(
  parameter  int IN_W   = 4,
  parameter  int STAGES = 3,
  parameter  int TAG_W  = 4,
  localparam int OUT_W  = out_width(IN_W, STAGES),
  localparam int CNT_W  = clog2(STAGES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  i_value,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OUT_W-1:0] o_value,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  // Level 0 is the input, level k+1 is the output of stage k. Levels have
  // different widths, so they are packed back to back in one flat vector.
  localparam int FLAT_W = lvl_off(IN_W, STAGES + 1);

  logic [FLAT_W-1:0]             d_flat;
  logic [STAGES:0][TAG_W-1:0]    tag_pipe;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES-1:0]             en;
  logic                          in_xfer;
  logic                          out_xfer;

  assign d_flat[IN_W-1:0] = i_value;
  assign tag_pipe[0]      = i_tag;
  assign vld_pipe[0]      = i_valid;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      localparam int W   = IN_W << k;
      localparam int SRC = lvl_off(IN_W, k);
      localparam int DST = lvl_off(IN_W, k + 1);

      // A stage may advance unless every stage downstream of it is full
      // and the consumer is stalling; equivalent to the ripple chain
      // en[k] = !v[k] | en[k+1] without a self-referencing vector.
      assign en[k] = o_ready | ~(&vld_pipe[STAGES:k+1]);

      pipeline_sq_stage #(.W(W), .TAG_W(TAG_W)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en      (en[k]),
        .in_v    (vld_pipe[k]),
        .in_d    (d_flat[SRC+W-1:SRC]),
        .in_tag  (tag_pipe[k]),
        .out_v   (vld_pipe[k+1]),
        .out_d   (d_flat[DST+2*W-1:DST]),
        .out_tag (tag_pipe[k+1])
      );
    end
  endgenerate

  assign i_ready  = en[0];
  assign o_value  = d_flat[FLAT_W-1:FLAT_W-OUT_W];
  assign o_tag    = tag_pipe[STAGES];
  assign o_valid  = vld_pipe[STAGES];
  assign in_xfer  = i_valid & i_ready;
  assign out_xfer = o_valid & o_ready;
  assign o_busy   = (o_count != '0);

  // Occupancy: up on accept, down on emit, unchanged when both or neither.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      o_count <= '0;
    else if (in_xfer && !out_xfer)
      o_count <= o_count + CNT_W'(1);
    else if (out_xfer && !in_xfer)
      o_count <= o_count - CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_pow2n.sv
// Self-checking bench for pipeline_pow2n: reference model is a queue of
// expected (x^(2^STAGES), tag) pairs in accept order.
module tb_pipeline_pow2n;

  localparam int S = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  i_value = '0;
  logic [3:0]  i_tag = '0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] o_value;
  logic [3:0]  o_tag;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_busy;
  logic [1:0]  o_count;

  // IN_W=8, STAGES=1 instance
  logic [7:0]  b_value = '0;
  logic        b_valid = 1'b0;
  logic        b_iready;
  logic [15:0] b_out;
  logic [3:0]  b_otag;
  logic        b_ovalid;
  logic        b_busy;
  logic [0:0]  b_count;

  // IN_W=2, STAGES=4 instance
  logic [1:0]  c_value = '0;
  logic        c_valid = 1'b0;
  logic        c_iready;
  logic [31:0] c_out;
  logic [3:0]  c_otag;
  logic        c_ovalid;
  logic        c_busy;
  logic [2:0]  c_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned val;
    logic [3:0]      tag;
  } item_t;
  item_t sb[$];

  always #5 clock = ~clock;

  pipeline_pow2n #(.IN_W(4), .STAGES(3), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .i_value(i_value), .i_tag(i_tag),
    .i_valid(i_valid), .i_ready(i_ready), .o_value(o_value), .o_tag(o_tag),
    .o_valid(o_valid), .o_ready(o_ready), .o_busy(o_busy), .o_count(o_count)
  );

  pipeline_pow2n #(.IN_W(8), .STAGES(1), .TAG_W(4)) dut_b (
    .clock(clock), .reset(reset), .i_value(b_value), .i_tag(4'd1),
    .i_valid(b_valid), .i_ready(b_iready), .o_value(b_out), .o_tag(b_otag),
    .o_valid(b_ovalid), .o_ready(1'b1), .o_busy(b_busy), .o_count(b_count)
  );

  pipeline_pow2n #(.IN_W(2), .STAGES(4), .TAG_W(4)) dut_c (
    .clock(clock), .reset(reset), .i_value(c_value), .i_tag(4'd2),
    .i_valid(c_valid), .i_ready(c_iready), .o_value(c_out), .o_tag(c_otag),
    .o_valid(c_ovalid), .o_ready(1'b1), .o_busy(c_busy), .o_count(c_count)
  );

  // x^(2^s) as plain repeated squaring
  function automatic longint unsigned pow_ref(input longint unsigned x, input int s);
    longint unsigned r;
    r = x;
    for (int i = 0; i < s; i++) r = r * r;
    return r;
  endfunction

  task automatic test_reset_state();
    checks++;
    if (o_valid !== 1'b0 || o_value !== '0 || o_tag !== '0 || o_count !== '0 ||
        o_busy !== 1'b0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: v=%0d val=%0d tag=%0d cnt=%0d busy=%0d rdy=%0d, required 0/0/0/0/0/1",
               o_valid, o_value, o_tag, o_count, o_busy, i_ready);
    end
  endtask

  task automatic test_defaults();
    logic [3:0]      vals[2] = '{4'd3, 4'd15};
    longint unsigned want[2] = '{64'd6561, 64'd2562890625};
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      o_ready = 1'b1; i_valid = 1'b1; i_value = vals[t]; i_tag = 4'd5;
      #1;
      @(negedge clock);
      i_valid = 1'b0; i_value = 4'hf; i_tag = 4'hf;
      for (int n = 1; n <= 3; n++) begin
        #1;
        checks++;
        if (o_valid !== (n == 3)) begin
          errors++;
          $display("FAIL latency_%0d: cycle %0d o_valid=%0d required %0d", t, n, o_valid, (n == 3));
        end
        if (n == 3) begin
          checks++;
          if ({32'd0, o_value} !== want[t] || o_tag !== 4'd5) begin
            errors++;
            $display("FAIL default_value_%0d: got %0d tag %0d, required %0d tag 5", t, o_value, o_tag, want[t]);
          end
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_stream();
    int pops = 0, first = -1, last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      o_ready = 1'b1;
      i_valid = (c < 8);
      i_value = 4'(c + 1);
      i_tag   = 4'(c);
      #1;
      if (c < 8) begin
        checks++;
        if (i_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready: cycle %0d i_ready=%0d required 1", c, i_ready);
        end
      end
      if (o_valid && o_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %0d, required no output", o_value);
        end else begin
          if ({32'd0, o_value} !== sb[0].val || o_tag !== sb[0].tag) begin
            errors++;
            $display("FAIL stream_data: got %0d/%0d required %0d/%0d", o_value, o_tag, sb[0].val, sb[0].tag);
          end
          void'(sb.pop_front());
        end
        if (first < 0) first = c;
        last = c;
        pops++;
      end
      if (i_valid && i_ready) sb.push_back('{pow_ref(64'(i_value), S), i_tag});
    end
    checks++;
    if (pops != 8 || last - first != 7) begin
      errors++;
      $display("FAIL stream_count: got %0d results over %0d cycles, required 8 over 8", pops, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held = '0;
    int pops = 0, c = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      o_ready = 1'b0; i_valid = 1'b1;
      i_value = 4'(n + 9); i_tag = 4'(n + 3);
      #1;
      if (n == 3) held = o_value;
      if (n == 5) begin
        checks++;
        if (o_count !== 2'd3 || i_ready !== 1'b0 || o_valid !== 1'b1 || o_value !== held ||
            {32'd0, o_value} !== sb[0].val) begin
          errors++;
          $display("FAIL stall_state: cnt=%0d rdy=%0d v=%0d val=%0d, required 3/0/1/%0d",
                   o_count, i_ready, o_valid, o_value, sb[0].val);
        end
      end
      if (i_valid && i_ready) sb.push_back('{pow_ref(64'(i_value), S), i_tag});
    end
    while (sb.size() != 0 && c < 20) begin
      @(negedge clock);
      o_ready = 1'b1; i_valid = 1'b0;
      #1;
      if (o_valid) begin
        checks++;
        if ({32'd0, o_value} !== sb[0].val || o_tag !== sb[0].tag) begin
          errors++;
          $display("FAIL drain_data: got %0d/%0d required %0d/%0d", o_value, o_tag, sb[0].val, sb[0].tag);
        end
        void'(sb.pop_front());
        pops++;
      end
      c++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (pops != 3 || o_valid !== 1'b0 || o_count !== 2'd0) begin
      errors++;
      $display("FAIL drain_count: popped %0d v=%0d cnt=%0d, required 3/0/0", pops, o_valid, o_count);
    end
    sb.delete();
  endtask

  task automatic test_random();
    int sent = 0, cyc = 0;
    while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
      @(negedge clock);
      i_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      i_value = 4'($urandom);
      i_tag   = 4'($urandom);
      o_ready = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (o_count !== 2'(sb.size()) || o_busy !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL rand_count: cycle %0d cnt=%0d busy=%0d required %0d", cyc, o_count, o_busy, sb.size());
      end
      if (o_valid && o_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got %0d, required no output", o_value);
        end else begin
          if ({32'd0, o_value} !== sb[0].val || o_tag !== sb[0].tag) begin
            errors++;
            $display("FAIL rand_data: got %0d/%0d required %0d/%0d", o_value, o_tag, sb[0].val, sb[0].tag);
          end
          void'(sb.pop_front());
        end
      end
      if (i_valid && i_ready) begin
        sb.push_back('{pow_ref(64'(i_value), S), i_tag});
        sent++;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL rand_timeout: sent %0d, %0d outstanding, required all drained", sent, sb.size());
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
  endtask

  task automatic test_reset_midrun();
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      o_ready = 1'b0; i_valid = 1'b1; i_value = 4'(n + 7); i_tag = 4'(n + 1);
    end
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    test_reset_state();
    @(negedge clock);
    i_valid = 1'b0;
    o_ready = 1'b1;
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic test_params();
    @(negedge clock);
    b_valid = 1'b1; b_value = 8'd255;
    c_valid = 1'b1; c_value = 2'd3;
    #1;
    checks++;
    if (b_iready !== 1'b1 || c_iready !== 1'b1) begin
      errors++;
      $display("FAIL param_ready: b=%0d c=%0d required 1/1", b_iready, c_iready);
    end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clock);
      b_valid = 1'b0; c_valid = 1'b0;
      #1;
      if (n == 1) begin
        checks++;
        if (b_ovalid !== 1'b1 || {48'd0, b_out} !== pow_ref(64'd255, 1)) begin
          errors++;
          $display("FAIL param_s1: v=%0d val=%0d required 1/65025", b_ovalid, b_out);
        end
      end
      checks++;
      if (c_ovalid !== (n == 4)) begin
        errors++;
        $display("FAIL param_s4_latency: cycle %0d v=%0d required %0d", n, c_ovalid, (n == 4));
      end
      if (n == 4) begin
        checks++;
        if ({32'd0, c_out} !== pow_ref(64'd3, 4)) begin
          errors++;
          $display("FAIL param_s4_value: got %0d required 43046721", c_out);
        end
      end
    end
  endtask

  initial begin
    #23;
    test_reset_state();
    @(negedge clock);
    reset = 1'b1;
    test_defaults();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midrun();
    test_defaults();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
